// File: rtl/update_dispatcher_if.sv
// Host-side push bus for update_dispatcher.
//   master : host / bus adapter  (drives in_valid, in_src, in_dst, in_e)
//   slave  : update_dispatcher   (drives in_ready)
// A transfer happens on any clock edge where in_valid && in_ready.
interface update_dispatcher_if #(
    parameter int VERT_BITS   = 6,
    parameter int WEIGHT_BITS = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [VERT_BITS-1:0]   in_src;
    logic [VERT_BITS-1:0]   in_dst;
    logic [WEIGHT_BITS-1:0] in_e;

    modport master (output in_valid, output in_src, output in_dst, output in_e, input in_ready);
    modport slave  (input in_valid, input in_src, input in_dst, input in_e, output in_ready);
endinterface

// File: rtl/update_dispatcher.sv
// update_dispatcher: initiator side of the Container update interface.
// Queues (src,dst,e) edge-weight updates from the host bus in a FIFO, presents
// one at a time on u_src/u_dst/u_e, pulses container_reset for one cycle to
// start a run, then waits for container_done (or a timeout) before the next.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   host (slave)     push bus: in_valid/in_ready/in_src/in_dst/in_e
//   u_src/u_dst/u_e  update presented to the Container, changes only on dispatch
//   container_reset  one-cycle start pulse
//   container_done   run-complete level from the Container
//   busy             a run is being kicked or awaited
//   fifo_level       queued entries, excluding the one in flight
//   done_count       completed runs (wraps)
//   err_timeout      sticky, set when a run is abandoned on timeout
//
// Build option: define COALESCE_EN to merge a push whose (src,dst) pair is
// already queued into that entry (weight overwritten, no append).
module update_dispatcher #(
    parameter int VERT_BITS   = 6,
    parameter int WEIGHT_BITS = 32,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    update_dispatcher_if.slave       host,
    output logic [VERT_BITS-1:0]     u_src,
    output logic [VERT_BITS-1:0]     u_dst,
    output logic [WEIGHT_BITS-1:0]   u_e,
    output logic                     container_reset,
    input  logic                     container_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              done_count,
    output logic                     err_timeout
);
    localparam int AW = $clog2(DEPTH);
    // TIMEOUT=1 still needs a 1-bit counter that compares against 0.
    localparam int TW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic [VERT_BITS-1:0]   src;
        logic [VERT_BITS-1:0]   dst;
        logic [WEIGHT_BITS-1:0] e;
    } entry_t;

    typedef enum logic [1:0] {IDLE, KICK, WAIT} state_t;

    state_t         state, state_n;
    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [TW-1:0]  tcnt;

    logic push, pop, append;
    logic tcnt_clr, tcnt_inc, done_inc, to_set;

    // Ready depends only on the registered count, never on in_valid.
    assign host.in_ready = (count != (AW+1)'(DEPTH));
    assign push          = host.in_valid && host.in_ready;
    assign fifo_level    = count;

`ifdef COALESCE_EN
    logic [DEPTH-1:0] hit;
    logic [AW-1:0]    hit_idx;
    logic             coalesce;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [AW-1:0] off;
            logic          occ;
            // Slot is live if its distance from the head is below count; the
            // head is excluded when it leaves this cycle so the push appends.
            assign off = AW'(gi) - rd_ptr;
            assign occ = ({1'b0, off} < count) && !(pop && (AW'(gi) == rd_ptr));
            assign hit[gi] = occ && (mem[gi].src == host.in_src) && (mem[gi].dst == host.in_dst);
        end
    endgenerate

    // Queued pairs are unique, so at most one bit of hit is set.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (hit[i]) hit_idx = AW'(i);
    end

    assign coalesce = push && (|hit);
    assign append   = push && !coalesce;
`else
    assign append   = push;
`endif

    // FIFO storage and pointers; pointers wrap naturally (DEPTH is 2^AW).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (append) begin
                mem[wr_ptr] <= '{src: host.in_src, dst: host.in_dst, e: host.in_e};
                wr_ptr      <= wr_ptr + 1'b1;
            end
`ifdef COALESCE_EN
            if (coalesce)
                mem[hit_idx].e <= host.in_e;
`endif
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, append} - {{AW{1'b0}}, pop};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // FSM next state and control strobes
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        tcnt_clr = 1'b0;
        tcnt_inc = 1'b0;
        done_inc = 1'b0;
        to_set   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = KICK;
                end
            end
            KICK: begin
                // container_done may still be high from the previous run;
                // it is deliberately not looked at here.
                tcnt_clr = 1'b1;
                state_n  = WAIT;
            end
            WAIT: begin
                if (container_done) begin
                    done_inc = 1'b1;
                    state_n  = IDLE;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    to_set  = 1'b1;
                    state_n = IDLE;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign container_reset = (state == KICK);
    assign busy            = (state != IDLE);

    // Datapath registers: presented update, timeout counter, status.
    always_ff @(posedge clk) begin
        if (reset) begin
            u_src       <= '0;
            u_dst       <= '0;
            u_e         <= '0;
            tcnt        <= '0;
            done_count  <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (pop) begin
                u_src <= mem[rd_ptr].src;
                u_dst <= mem[rd_ptr].dst;
                u_e   <= mem[rd_ptr].e;
            end
            if (tcnt_clr)      tcnt <= '0;
            else if (tcnt_inc) tcnt <= tcnt + 1'b1;
            if (done_inc) done_count  <= done_count + 16'd1;
            if (to_set)   err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_update_dispatcher.sv
// Self-checking bench for update_dispatcher: directed scenarios plus a
// randomized phase, all compared cycle by cycle against a queue-based model.
module tb_update_dispatcher;
    localparam int VB    = 6;
    localparam int WB    = 32;
    localparam int DEPTH = 8;
    localparam int TO    = 32;

    typedef struct {
        logic [VB-1:0] src;
        logic [VB-1:0] dst;
        logic [WB-1:0] e;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic container_done = 1'b0;
    logic [VB-1:0] u_src, u_dst;
    logic [WB-1:0] u_e;
    logic container_reset, busy, err_timeout;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0] done_count;

    update_dispatcher_if #(.VERT_BITS(VB), .WEIGHT_BITS(WB)) bus ();

    update_dispatcher #(.VERT_BITS(VB), .WEIGHT_BITS(WB), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .host(bus),
        .u_src(u_src), .u_dst(u_dst), .u_e(u_e),
        .container_reset(container_reset), .container_done(container_done),
        .busy(busy), .fifo_level(fifo_level), .done_count(done_count),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending updates as a queue, the update in flight,
    // and the run phase (0 idle, 1 pulse cycle, 2 awaiting done).
    ent_t m_q[$];
    ent_t m_u;
    int   m_ph   = 0;
    int   m_wait = 0;
    int   m_cnt  = 0;
    bit   m_err  = 0;
    int   age    = 0;   // cycles since the model entered the pulse phase
    int   mode   = 0;   // stub: 0 done after lat, 1 never, 2 always, 3 random
    int   lat    = 20;

    task automatic model_edge();
        bit   rdy, take, merged;
        ent_t n;
        rdy  = m_q.size() < DEPTH;
        take = (m_ph == 0) && (m_q.size() > 0);
        age++;
        if (reset) begin
            m_q.delete();
            m_ph = 0; m_wait = 0; m_cnt = 0; m_err = 0;
            m_u = '{src: '0, dst: '0, e: '0};
            return;
        end
        merged = 0;
        n = '{src: bus.in_src, dst: bus.in_dst, e: bus.in_e};
        if (bus.in_valid && rdy) begin
`ifdef COALESCE_EN
            for (int k = (take ? 1 : 0); k < m_q.size(); k++)
                if (m_q[k].src == n.src && m_q[k].dst == n.dst) begin
                    m_q[k].e = n.e;
                    merged = 1;
                end
`endif
        end
        case (m_ph)
            0: if (take) begin m_u = m_q.pop_front(); m_ph = 1; age = 0; end
            1: begin m_ph = 2; m_wait = 0; end
            default: begin
                if (container_done) begin m_cnt = (m_cnt + 1) & 16'hFFFF; m_ph = 0; end
                else if (m_wait == TO - 1) begin m_err = 1; m_ph = 0; end
                else m_wait++;
            end
        endcase
        if (bus.in_valid && rdy && !merged) m_q.push_back(n);
    endtask

    task automatic drive_done();
        case (mode)
            0: container_done = (m_ph == 2) && (age >= lat);
            1: container_done = 1'b0;
            2: container_done = 1'b1;
            default: container_done = ($urandom_range(0, 4) == 0);
        endcase
    endtask

    task automatic check_all();
        chk("in_ready",   bus.in_ready,    m_q.size() < DEPTH);
        chk("fifo_level", fifo_level,      m_q.size());
        chk("busy",       busy,            m_ph != 0);
        chk("pulse",      container_reset, m_ph == 1);
        chk("u_src",      u_src,           m_u.src);
        chk("u_dst",      u_dst,           m_u.dst);
        chk("u_e",        u_e,             m_u.e);
        chk("done_count", done_count,      m_cnt);
        chk("err",        err_timeout,     m_err);
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
        drive_done();
    endtask

    task automatic push(input int s, input int d, input logic [WB-1:0] e);
        bus.in_valid = 1'b1;
        bus.in_src   = VB'(s);
        bus.in_dst   = VB'(d);
        bus.in_e     = e;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((m_ph != 0 || m_q.size() != 0) && i < budget) begin cyc(); i++; end
        chk("drain_in_budget", (m_ph != 0 || m_q.size() != 0), 0);
    endtask

    int base;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_src   = '0;
        bus.in_dst   = '0;
        bus.in_e     = '0;
        @(posedge clk);
        model_edge();
        #1;
        cyc();                      // reset held: all outputs zero
        reset = 1'b0;

        // 1: single update, done 20 cycles after the pulse
        mode = 0; lat = 20;
        push(3, 5, 32'h100);
        cyc();
        chk("t1_pulse", container_reset, 1);
        chk("t1_src", u_src, 3);
        chk("t1_e", u_e, 32'h100);
        drain(60);
        chk("t1_count", done_count, 1);
        chk("t1_busy", busy, 0);

        // 2: done never comes; 10 back-to-back pushes
        mode = 1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_src = VB'(i); bus.in_dst = VB'(i + 20); bus.in_e = WB'(i * 3);
            cyc();
        end
        bus.in_valid = 1'b0;
        cyc();
        chk("t2_ready", bus.in_ready, 0);
        chk("t2_level", fifo_level, 8);

        // 3: every run times out; queued updates still dispatched in turn
        drain(9 * (TO + 4));
        chk("t3_err", err_timeout, 1);

        // 4: coalescing while busy
        mode = 0; lat = 6;
        push(9, 9, 1);
        push(1, 2, 10);
        push(4, 5, 7);
        push(1, 2, 20);
`ifdef COALESCE_EN
        chk("t4_level", fifo_level, 2);
`else
        chk("t4_level", fifo_level, 3);
`endif
        drain(100);

        // 5: reset while waiting with 3 queued
        mode = 1;
        for (int i = 0; i < 4; i++) push(i + 1, i + 2, WB'(i + 100));
        for (int i = 0; i < 10 && m_ph != 2; i++) cyc();
        chk("t5_queued", fifo_level, 3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("t5_level", fifo_level, 0);
        chk("t5_err", err_timeout, 0);
        chk("t5_count", done_count, 0);
        mode = 0; lat = 3;
        push(7, 0, -32'sd5);
        cyc();
        chk("t5_neg", u_e, 32'hFFFF_FFFB);
        drain(40);

        // 6: done stuck high across runs counts once per run
        mode = 2;
        base = m_cnt;
        push(11, 12, 1);
        push(13, 14, 2);
        push(15, 16, 3);
        drain(40);
        chk("t6_count", done_count, base + 3);

        // random traffic with random done and occasional reset
        mode = 3;
        for (int i = 0; i < 800; i++) begin
            bus.in_valid = ($urandom_range(0, 1) == 1);
            bus.in_src = VB'($urandom_range(0, 3));
            bus.in_dst = VB'($urandom_range(0, 3));
            bus.in_e = $urandom;
            reset = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        drain(12 * (TO + 4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
